rpc_echo_app_engine: RTL and testbench

Parametrised per-flow RPC echo engine: control FSM plus datapath in one block.

---
 rtl/rpc_echo_app_pkg.sv | 25 ++
 rtl/rpc_echo_app_pattern_gen.sv | 44 ++++
 rtl/rpc_echo_app_engine.sv | 190 +++++++++++++++++++
 tb/tb_rpc_echo_app_engine.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/rpc_echo_app_pkg.sv
// Shared types for the RPC echo engine: request header layout, FSM states, header size.
// Used by rpc_echo_app_engine and rpc_echo_app_pattern_gen.
package rpc_echo_app_pkg;

    localparam int HDR_BYTES = 32;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PTR_RD,
        ST_CHECK,
        ST_HDR_REQ,
        ST_HDR_WAIT,
        ST_WR_DATA,
        ST_PTR_WR,
        ST_REQUEUE
    } state_e;

    // Header occupies the top HDR_BYTES of the read beat, rd_len in the most significant bits.
    typedef struct packed {
        logic [15:0]              rd_len;
        logic [15:0]              wr_len;
        logic [HDR_BYTES*8-33:0]  padding;
    } req_hdr_struct;

endpackage

// File: rtl/rpc_echo_app_pattern_gen.sv
// Fill-pattern beat generator: byte k of the stream is 'a' + (k mod 26), byte 0 at the MSB.
// Only the running byte offset modulo 26 is kept, since that alone decides every byte.
module rpc_echo_app_pattern_gen #(
    parameter int DATA_W = 256
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_i,
    input  logic              advance_i,
    output logic [DATA_W-1:0] beat_o
);
    import rpc_echo_app_pkg::*;

    localparam int DATA_BYTES = DATA_W / 8;
    localparam int STEP       = DATA_BYTES % 26;

    logic [4:0] base_q, base_d;
    logic [5:0] base_nxt;

    assign base_nxt = {1'b0, base_q} + 6'(STEP);

    always_comb begin
        base_d = base_q;
        if (load_i)
            base_d = 5'd0;
        else if (advance_i)
            base_d = (base_nxt >= 6'd26) ? 5'(base_nxt - 6'd26) : 5'(base_nxt);
    end

    always_ff @(posedge clk) begin
        if (rst)
            base_q <= 5'd0;
        else
            base_q <= base_d;
    end

    for (genvar i = 0; i < DATA_BYTES; i++) begin : g_byte
        logic [5:0] sum;
        assign sum = {1'b0, base_q} + 6'(i % 26);
        assign beat_o[DATA_W-1-8*i -: 8] =
            8'h61 + ((sum >= 6'd26) ? 8'(sum - 6'd26) : 8'(sum));
    end

endmodule

// File: rtl/rpc_echo_app_engine.sv
// Per-flow RPC echo engine: reads flow pointers, consumes one request header, writes a fill-pattern response.
// Option RPC_ECHO_APP_ECHO_HDR_EN: beat 0 of the response carries the received header verbatim.
module rpc_echo_app_engine #(
    parameter int FLOW_ID_W      = 10,
    parameter int TX_PTR_W       = 14,
    parameter int RX_PTR_W       = 14,
    parameter int DATA_W         = 256,
    parameter int MAX_RESP_BYTES = 1024
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   flow_val,
    input  logic [FLOW_ID_W-1:0]                   flow_flowid,
    output logic                                   flow_rdy,
    output logic [FLOW_ID_W-1:0]                   curr_flowid,
    output logic                                   requeue_val,
    input  logic                                   requeue_rdy,
    output logic                                   ptr_rd_val,
    input  logic [2*(TX_PTR_W+1)+2*(RX_PTR_W+1)-1:0] ptr_rd_resp,
    output logic                                   ptr_wr_val,
    output logic [TX_PTR_W+RX_PTR_W+1:0]           ptr_wr_data,
    output logic                                   rd_req_val,
    input  logic                                   rd_req_rdy,
    output logic [RX_PTR_W:0]                      rd_req_offset,
    input  logic                                   rd_resp_val,
    input  logic [DATA_W-1:0]                      rd_resp_data,
    output logic                                   wr_val,
    input  logic                                   wr_rdy,
    output logic [TX_PTR_W:0]                      wr_ptr,
    output logic [15:0]                            wr_size,
    output logic [DATA_W-1:0]                      wr_data,
    output logic                                   wr_last,
    output logic [$clog2(DATA_W/8)-1:0]            wr_padbytes
);
    import rpc_echo_app_pkg::*;

    localparam int DATA_BYTES = DATA_W / 8;
    localparam int PAD_W      = $clog2(DATA_BYTES);
    localparam int TXP        = TX_PTR_W + 1;
    localparam int RXP        = RX_PTR_W + 1;
    localparam logic [TXP:0] TX_CAP = (TXP+1)'(1) << TX_PTR_W;

    state_e                 state_q, state_d;
    logic [FLOW_ID_W-1:0]   flowid_q;
    logic                   rd_pend_q;
    logic [TXP-1:0]         tx_head_q, tx_tail_q;
    logic [RXP-1:0]         rx_head_q, rx_commit_q;
    logic [15:0]            resp_bytes_q, bytes_left_q;
    logic                   first_beat_q;

    req_hdr_struct          hdr_in;
    logic [15:0]            resp_in;
    logic [RXP-1:0]         rx_used;
    logic [TXP-1:0]         tx_used;
    logic [TXP:0]           tx_left;
    logic                   last_beat;
    logic [15:0]            neg_resp;
    logic                   pat_load, pat_adv;
    logic [DATA_W-1:0]      pat_beat;
    logic                   unused_hdr;

    assign hdr_in     = req_hdr_struct'(rd_resp_data[DATA_W-1 -: HDR_BYTES*8]);
    assign resp_in    = (32'(hdr_in.wr_len) > MAX_RESP_BYTES) ? 16'(MAX_RESP_BYTES) : hdr_in.wr_len;
    assign rx_used    = rx_commit_q - rx_head_q;
    assign tx_used    = tx_tail_q - tx_head_q;
    assign tx_left    = TX_CAP - {1'b0, tx_used};
    assign last_beat  = 32'(bytes_left_q) <= DATA_BYTES;
    assign neg_resp   = 16'd0 - resp_bytes_q;
    assign unused_hdr = ^{hdr_in.rd_len, hdr_in.padding, rd_resp_data};

    assign pat_load = (state_q == ST_HDR_WAIT) && rd_resp_val;
    assign pat_adv  = (state_q == ST_WR_DATA) && wr_rdy;

    rpc_echo_app_pattern_gen #(.DATA_W(DATA_W)) u_pattern (
        .clk       (clk),
        .rst       (rst),
        .load_i    (pat_load),
        .advance_i (pat_adv),
        .beat_o    (pat_beat)
    );

`ifdef RPC_ECHO_APP_ECHO_HDR_EN
    logic [DATA_W-1:0] hdr_q;
    logic [DATA_W-1:0] beat_data;
    assign beat_data = first_beat_q ? hdr_q : pat_beat;
`else
    logic [DATA_W-1:0] beat_data;
    logic              unused_first;
    assign beat_data    = pat_beat;
    assign unused_first = first_beat_q;
`endif

    always_ff @(posedge clk) begin
        if (rst)
            state_q <= ST_IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:     if (flow_val) state_d = ST_PTR_RD;
            ST_PTR_RD:   if (rd_pend_q) state_d = ST_CHECK;
            ST_CHECK:    state_d = (32'(rx_used) >= HDR_BYTES) ? ST_HDR_REQ : ST_REQUEUE;
            ST_HDR_REQ:  if (rd_req_rdy) state_d = ST_HDR_WAIT;
            ST_HDR_WAIT: begin
                if (rd_resp_val) begin
                    if (resp_in == 16'd0)
                        state_d = ST_PTR_WR;
                    else if (32'(tx_left) < 32'(resp_in))
                        state_d = ST_REQUEUE;
                    else
                        state_d = ST_WR_DATA;
                end
            end
            ST_WR_DATA:  if (wr_rdy && last_beat) state_d = ST_PTR_WR;
            ST_PTR_WR:   state_d = ST_REQUEUE;
            ST_REQUEUE:  if (requeue_rdy) state_d = ST_IDLE;
            default:     state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        flow_rdy      = (state_q == ST_IDLE);
        ptr_rd_val    = (state_q == ST_PTR_RD) && !rd_pend_q;
        rd_req_val    = (state_q == ST_HDR_REQ);
        wr_val        = (state_q == ST_WR_DATA);
        ptr_wr_val    = (state_q == ST_PTR_WR);
        requeue_val   = (state_q == ST_REQUEUE);
        curr_flowid   = flowid_q;
        rd_req_offset = rx_head_q;
        wr_ptr        = tx_tail_q;
        wr_size       = resp_bytes_q;
        wr_data       = beat_data;
        wr_last       = last_beat;
        wr_padbytes   = last_beat ? neg_resp[PAD_W-1:0] : '0;
        ptr_wr_data   = {TXP'(32'(tx_tail_q) + 32'(resp_bytes_q)),
                         RXP'(32'(rx_head_q) + HDR_BYTES)};
    end

    // The pointer response arrives the cycle after the strobe; rd_pend_q marks that cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            flowid_q     <= '0;
            rd_pend_q    <= 1'b0;
            tx_head_q    <= '0;
            tx_tail_q    <= '0;
            rx_head_q    <= '0;
            rx_commit_q  <= '0;
            resp_bytes_q <= '0;
            bytes_left_q <= '0;
            first_beat_q <= 1'b0;
`ifdef RPC_ECHO_APP_ECHO_HDR_EN
            hdr_q        <= '0;
`endif
        end else begin
            case (state_q)
                ST_IDLE: if (flow_val) flowid_q <= flow_flowid;
                ST_PTR_RD: begin
                    rd_pend_q <= !rd_pend_q;
                    if (rd_pend_q) begin
                        tx_head_q   <= ptr_rd_resp[2*RXP+2*TXP-1 -: TXP];
                        tx_tail_q   <= ptr_rd_resp[2*RXP+TXP-1 -: TXP];
                        rx_head_q   <= ptr_rd_resp[2*RXP-1 -: RXP];
                        rx_commit_q <= ptr_rd_resp[RXP-1:0];
                    end
                end
                ST_HDR_WAIT: begin
                    if (rd_resp_val) begin
                        resp_bytes_q <= resp_in;
                        bytes_left_q <= resp_in;
                        first_beat_q <= 1'b1;
`ifdef RPC_ECHO_APP_ECHO_HDR_EN
                        hdr_q        <= rd_resp_data;
`endif
                    end
                end
                ST_WR_DATA: begin
                    if (wr_rdy) begin
                        bytes_left_q <= bytes_left_q - 16'(DATA_BYTES);
                        first_beat_q <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_rpc_echo_app_engine.sv
// Randomized bench for rpc_echo_app_engine against a transaction-level reference model.
// Directed cases cover empty RX, single/multi-beat writes, TX-full requeue, pointer wrap, stalls and reset.
module tb_rpc_echo_app_engine;
    localparam int FW = 10;
    localparam int TW = 14;
    localparam int RW = 14;
    localparam int DW = 256;
    localparam int DB = DW / 8;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           flow_val = 1'b0;
    logic [FW-1:0]  flow_flowid = '0;
    logic           flow_rdy;
    logic [FW-1:0]  curr_flowid;
    logic           requeue_val;
    logic           requeue_rdy = 1'b0;
    logic           ptr_rd_val;
    logic [59:0]    ptr_rd_resp = '0;
    logic           ptr_wr_val;
    logic [29:0]    ptr_wr_data;
    logic           rd_req_val;
    logic           rd_req_rdy = 1'b0;
    logic [RW:0]    rd_req_offset;
    logic           rd_resp_val = 1'b0;
    logic [DW-1:0]  rd_resp_data = '0;
    logic           wr_val;
    logic           wr_rdy = 1'b0;
    logic [TW:0]    wr_ptr;
    logic [15:0]    wr_size;
    logic [DW-1:0]  wr_data;
    logic           wr_last;
    logic [4:0]     wr_padbytes;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    rpc_echo_app_engine #(.FLOW_ID_W(FW), .TX_PTR_W(TW), .RX_PTR_W(RW), .DATA_W(DW),
                          .MAX_RESP_BYTES(1024)) dut (
        .clk(clk), .rst(rst),
        .flow_val(flow_val), .flow_flowid(flow_flowid), .flow_rdy(flow_rdy),
        .curr_flowid(curr_flowid), .requeue_val(requeue_val), .requeue_rdy(requeue_rdy),
        .ptr_rd_val(ptr_rd_val), .ptr_rd_resp(ptr_rd_resp),
        .ptr_wr_val(ptr_wr_val), .ptr_wr_data(ptr_wr_data),
        .rd_req_val(rd_req_val), .rd_req_rdy(rd_req_rdy), .rd_req_offset(rd_req_offset),
        .rd_resp_val(rd_resp_val), .rd_resp_data(rd_resp_data),
        .wr_val(wr_val), .wr_rdy(wr_rdy), .wr_ptr(wr_ptr), .wr_size(wr_size),
        .wr_data(wr_data), .wr_last(wr_last), .wr_padbytes(wr_padbytes)
    );

    task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Byte k of the response stream is 'a' + k mod 26, byte 0 at the MSB.
    function automatic logic [DW-1:0] exp_beat(input int b, input logic [DW-1:0] hdr);
        logic [DW-1:0] r;
        r = hdr;
`ifdef RPC_ECHO_APP_ECHO_HDR_EN
        if (b == 0) return r;
`endif
        for (int j = 0; j < DB; j++)
            r[DW-1-8*j -: 8] = 8'h61 + 8'((b*DB + j) % 26);
        return r;
    endfunction

    task automatic run_txn(input logic [14:0] txh, input int txu, input logic [14:0] rxh,
                           input int rxu, input int wl, input int rdy_pct, input int rst_beat);
        logic [14:0]   txt, rxc;
        logic [DW-1:0] hdr, prev_data;
        logic [FW-1:0] fid;
        logic          prev_last, prev_stall, prd_prev, flow_sent, done, do_rst, last_exp;
        int resp, tx_left, exp_beats, beat, n_prd, n_rdreq, n_pwr, resp_delay, cyc, pad_exp;
        int has_hdr, do_pwr, do_write;

        txt  = 15'(32'(txh) + txu);
        rxc  = 15'(32'(rxh) + rxu);
        fid  = FW'($urandom);
        hdr  = {16'($urandom), 16'(wl), {7{$urandom}}};
        resp = (wl > 1024) ? 1024 : wl;
        tx_left   = 16384 - txu;
        has_hdr   = (rxu >= 32) ? 1 : 0;
        do_write  = (has_hdr != 0 && resp != 0 && tx_left >= resp) ? 1 : 0;
        do_pwr    = (has_hdr != 0 && (resp == 0 || tx_left >= resp)) ? 1 : 0;
        exp_beats = (do_write != 0) ? (resp + DB - 1) / DB : 0;
        pad_exp   = (DB - resp % DB) % DB;

        beat = 0; n_prd = 0; n_rdreq = 0; n_pwr = 0; resp_delay = -1; cyc = 0;
        prev_stall = 0; prd_prev = 0; flow_sent = 0; done = 0; do_rst = 0;
        prev_data = '0; prev_last = 0;

        while (!done && cyc < 3000) begin
            @(negedge clk);
            cyc++;
            ptr_rd_resp = prd_prev ? {txh, txt, rxh, rxc} : 60'({$urandom, $urandom});
            prd_prev    = ptr_rd_val;
            if (ptr_rd_val) n_prd++;

            if (prev_stall) begin
                chk("hold_data", wr_data, prev_data);
                chk("hold_last", wr_last, prev_last);
            end

            flow_val = 1'b0;
            if (!flow_sent && flow_rdy) begin
                flow_val = 1'b1; flow_flowid = fid; flow_sent = 1;
            end

            rd_resp_val  = 1'b0;
            rd_resp_data = {8{$urandom}};
            if (resp_delay == 0) begin
                rd_resp_val = 1'b1; rd_resp_data = hdr; resp_delay = -1;
            end else if (resp_delay > 0) resp_delay--;

            rd_req_rdy = 1'($urandom);
            if (rd_req_val && rd_req_rdy) begin
                n_rdreq++;
                chk("rd_offset", rd_req_offset, rxh);
                resp_delay = $urandom_range(0, 2);
            end

            wr_rdy = ($urandom_range(0, 99) < rdy_pct);
            prev_stall = wr_val && !wr_rdy;
            prev_data  = wr_data;
            prev_last  = wr_last;
            if (wr_val && wr_rdy) begin
                last_exp = (beat == exp_beats - 1);
                chk("wr_data", wr_data, exp_beat(beat, hdr));
                chk("wr_last", wr_last, last_exp);
                chk("wr_pad", wr_padbytes, last_exp ? pad_exp : 0);
                chk("wr_ptr", wr_ptr, txt);
                chk("wr_size", wr_size, resp);
                beat++;
                if (rst_beat != 0 && beat == rst_beat) do_rst = 1;
            end

            if (ptr_wr_val) begin
                n_pwr++;
                chk("ptr_wr", ptr_wr_data, {15'(32'(txt) + resp), 15'(32'(rxh) + 32)});
            end

            requeue_rdy = 1'($urandom);
            if (requeue_val && requeue_rdy) begin
                chk("requeue_id", curr_flowid, fid);
                done = 1;
            end

            if (do_rst) begin
                rst = 1'b1;
                @(negedge clk);
                chk("rst_flow_rdy", flow_rdy, 1);
                chk("rst_wr_val", wr_val, 0);
                chk("rst_ptr_wr", ptr_wr_val, 0);
                chk("rst_flowid", curr_flowid, 0);
                rst = 1'b0; wr_rdy = 1'b0; requeue_rdy = 1'b0;
                done = 1;
            end
        end
        flow_val = 1'b0; rd_resp_val = 1'b0;

        chk("txn_done", done, 1);
        if (do_rst) begin
            chk("rst_no_pwr", n_pwr, 0);
        end else begin
            chk("n_ptr_rd", n_prd, 1);
            chk("n_rd_req", n_rdreq, has_hdr);
            chk("n_beats", beat, exp_beats);
            chk("n_ptr_wr", n_pwr, do_pwr);
        end
    endtask

    initial begin
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_flow_rdy", flow_rdy, 1);
        chk("rst_ptr_rd", ptr_rd_val, 0);
        chk("rst_rd_req", rd_req_val, 0);
        chk("rst_wr_val", wr_val, 0);
        chk("rst_ptr_wr", ptr_wr_val, 0);
        chk("rst_requeue", requeue_val, 0);
        chk("rst_flowid", curr_flowid, 0);

        run_txn(15'h0100, 0,     15'h0040, 0,  32,   100, 0);  // RX empty
        run_txn(15'h0100, 0,     15'h0040, 32, 32,   100, 0);  // single beat
        run_txn(15'h0200, 100,   15'h0300, 64, 70,   100, 0);  // 3 beats, pad 26
        run_txn(15'h0000, 16368, 15'h0000, 32, 32,   100, 0);  // TX nearly full
        run_txn(15'h1000, 16320, 15'h0000, 32, 64,   100, 0);  // TX exactly fits
        run_txn(15'h0010, 0,     15'h7FF0, 32, 40,   100, 0);  // RX pointer wrap
        run_txn(15'h7FF0, 40,    15'h0020, 31, 40,   100, 0);  // one byte short of a header
        run_txn(15'h0000, 0,     15'h0000, 32, 0,    100, 0);  // zero-length response
        run_txn(15'h0400, 0,     15'h0000, 96, 2000, 70,  0);  // capped at 1024
        run_txn(15'h0500, 10,    15'h0100, 32, 200,  25,  0);  // heavy stalls
        run_txn(15'h0600, 0,     15'h0200, 32, 300,  100, 2);  // reset mid-burst

        for (int t = 0; t < 40; t++) begin
            int txu, rxu, wl;
            txu = ($urandom_range(0, 3) == 0) ? $urandom_range(16000, 16384) : $urandom_range(0, 16384);
            rxu = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 40) : $urandom_range(32, 400);
            wl  = ($urandom_range(0, 7) == 0) ? $urandom_range(1000, 1500) : $urandom_range(0, 300);
            run_txn(15'($urandom), txu, 15'($urandom), rxu, wl, $urandom_range(30, 100), 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
